// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and the
// GO/HOLD/FLUSH pipeline-control codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACC = 2'd1,
    ST_DM_ACC = 2'd2
  } arb_state_t;

  localparam logic [1:0] CTRL_GO    = 2'b00;
  localparam logic [1:0] CTRL_HOLD  = 2'b01;
  localparam logic [1:0] CTRL_FLUSH = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-access wait counter; expired is raised once TIMEOUT cycles have
// passed without mem_ready since the last clear.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // Saturates at the limit so a stalled access can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and the MEM stage; data
// side wins from IDLE, then the two alternate while both keep requesting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        pc_enable,
  output logic [1:0]  if_id_ctrl,
  output logic [1:0]  id_ex_ctrl,
  output logic [1:0]  ex_mem_ctrl,
  output logic [1:0]  mem_wb_ctrl,
  output logic        timeout_err
);

  arb_state_t  r_state;
  logic [31:0] r_addr;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic        r_timeout_err;

  logic w_idle, w_in_if, w_in_dm, w_in_acc;
  logic w_expired, w_timeout;
  logic w_finish_if, w_finish_dm;
  logic w_grant_if, w_grant_dm;
  logic w_dm_stall, w_if_stall;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_in_if  = (r_state == ST_IF_ACC);
  assign w_in_dm  = (r_state == ST_DM_ACC);
  assign w_in_acc = w_in_if | w_in_dm;

  // A real mem_ready always wins over an expiry in the same cycle.
  assign w_timeout   = w_in_acc & ~mem_ready & w_expired;
  assign w_finish_if = w_in_if & (mem_ready | w_expired);
  assign w_finish_dm = w_in_dm & (mem_ready | w_expired);

  // Hand-over only on a genuine completion, never on a timeout.
  assign w_grant_dm = (w_idle & dm_req) | (w_in_if & mem_ready & dm_req);
  assign w_grant_if = (w_idle & ~dm_req & if_req) | (w_in_dm & mem_ready & if_req);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_grant_dm | w_grant_if),
    .enable  (w_in_acc & ~mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_wr          <= 1'b0;
      r_wdata       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant_dm) begin
        r_state <= ST_DM_ACC;
        r_addr  <= dm_addr;
        r_wr    <= dm_wr;
        r_wdata <= dm_wdata;
      end else if (w_grant_if) begin
        r_state <= ST_IF_ACC;
        r_addr  <= if_addr;
        r_wr    <= 1'b0;
        r_wdata <= '0;
      end else if (w_finish_if || w_finish_dm) begin
        r_state <= ST_IDLE;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_req     = w_in_acc;
  assign mem_wr      = r_wr & w_in_dm;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign timeout_err = r_timeout_err;

  assign if_done  = w_finish_if;
  assign dm_done  = w_finish_dm;
  assign if_rdata = (w_in_if & mem_ready) ? mem_rdata : 32'h0;
  assign dm_rdata = (w_in_dm & mem_ready) ? mem_rdata : 32'h0;

  assign w_dm_stall = dm_req & ~dm_done;
  assign w_if_stall = if_req & ~if_done;

  // A data stall freezes the front of the pipe and bubbles into WB.
  always_comb begin
    pc_enable   = 1'b1;
    if_id_ctrl  = CTRL_GO;
    id_ex_ctrl  = CTRL_GO;
    ex_mem_ctrl = CTRL_GO;
    mem_wb_ctrl = CTRL_GO;
    if (w_dm_stall) begin
      pc_enable   = 1'b0;
      if_id_ctrl  = CTRL_HOLD;
      id_ex_ctrl  = CTRL_HOLD;
      ex_mem_ctrl = CTRL_HOLD;
      mem_wb_ctrl = CTRL_FLUSH;
    end else if (w_if_stall) begin
      pc_enable   = 1'b0;
      if_id_ctrl  = CTRL_FLUSH;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the memory-port arbiter: priority, alternation, store
// latching, fetch stall, async reset and timeout (TIMEOUT=4).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_wr, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, dm_done, mem_req, mem_wr, pc_enable, timeout_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [1:0]  if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;

  int checks = 0;
  int failures = 0;
  logic exp_dm;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .if_id_ctrl(if_id_ctrl), .id_ex_ctrl(id_ex_ctrl),
    .ex_mem_ctrl(ex_mem_ctrl), .mem_wb_ctrl(mem_wb_ctrl), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic [1:0] a,
                          input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    chk({tag, "_pc"}, pc_enable, pc);
    chk({tag, "_ifid"}, if_id_ctrl, a);
    chk({tag, "_idex"}, id_ex_ctrl, b);
    chk({tag, "_exmem"}, ex_mem_ctrl, c);
    chk({tag, "_memwb"}, mem_wb_ctrl, d);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_wr = 0; mem_ready = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_dm_done", dm_done, 0);
    chk_ctrl("rst", 1, CTRL_GO, CTRL_GO, CTRL_GO, CTRL_GO);
    #6 rst_n = 1'b1;

    // A: load and fetch together, data first, ready after 2 wait cycles
    tick; dm_req = 1; dm_addr = 32'h200; if_req = 1; if_addr = 32'h40; settle;
    chk("a_idle_mem_req", mem_req, 0);
    chk_ctrl("a_idle", 0, CTRL_HOLD, CTRL_HOLD, CTRL_HOLD, CTRL_FLUSH);
    tick; settle;
    chk("a_c0_mem_req", mem_req, 1);
    chk("a_c0_addr", mem_addr, 32'h200);
    chk("a_c0_mem_wr", mem_wr, 0);
    chk("a_c0_dm_done", dm_done, 0);
    chk("a_c0_memwb", mem_wb_ctrl, CTRL_FLUSH);
    tick; settle;
    chk("a_c1_dm_done", dm_done, 0);
    chk("a_c1_memwb", mem_wb_ctrl, CTRL_FLUSH);
    tick; mem_ready = 1; mem_rdata = 32'hDEADBEEF; settle;
    chk("a_dm_done", dm_done, 1);
    chk("a_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("a_if_done_low", if_done, 0);
    chk_ctrl("a_done", 0, CTRL_FLUSH, CTRL_GO, CTRL_GO, CTRL_GO);
    $display("txn A load addr=0x200 rdata=0x%0h", dm_rdata);
    tick; dm_req = 0; mem_ready = 0; settle;
    chk("a_if_mem_req", mem_req, 1);
    chk("a_if_addr", mem_addr, 32'h40);
    chk("a_if_dm_done", dm_done, 0);
    chk("a_if_ifid", if_id_ctrl, CTRL_FLUSH);
    mem_ready = 1; mem_rdata = 32'hCAFEF00D; settle;
    chk("a_if_done", if_done, 1);
    chk("a_if_rdata", if_rdata, 32'hCAFEF00D);
    $display("txn A fetch addr=0x40 rdata=0x%0h", if_rdata);
    tick; if_req = 0; mem_ready = 0; settle;
    chk("a_end_mem_req", mem_req, 0);
    chk("a_end_pc", pc_enable, 1);

    // B: both held, mem_ready every cycle -> DM, IF, DM, IF, DM
    tick; dm_req = 1; if_req = 1; dm_addr = 32'h300; if_addr = 32'h80;
    mem_ready = 1; mem_rdata = 32'h11110000; settle;
    chk("b_idle_dm_done", dm_done, 0);
    chk("b_idle_if_done", if_done, 0);
    chk("b_idle_mem_req", mem_req, 0);
    for (int k = 0; k < 5; k++) begin
      tick; mem_rdata = 32'h11110000 + k; if (k == 4) if_req = 0; settle;
      exp_dm = (k % 2 == 0);
      chk("b_dm_done", dm_done, exp_dm);
      chk("b_if_done", if_done, !exp_dm);
      chk("b_addr", mem_addr, exp_dm ? 32'h300 : 32'h80);
      chk("b_rdata", exp_dm ? dm_rdata : if_rdata, 32'h11110000 + k);
      $display("txn B%0d grant=%s addr=0x%0h", k, exp_dm ? "DM" : "IF", mem_addr);
    end
    tick; dm_req = 0; mem_ready = 0; settle;
    chk("b_end_mem_req", mem_req, 0);
    chk("b_end_pc", pc_enable, 1);

    // C: store latched at grant, inputs change afterwards
    tick; dm_req = 1; dm_wr = 1; dm_addr = 32'h100; dm_wdata = 32'h12345678; settle;
    tick; dm_addr = 32'hFFF; dm_wdata = 32'h0; dm_wr = 0; settle;
    chk("c_c0_mem_wr", mem_wr, 1);
    chk("c_c0_addr", mem_addr, 32'h100);
    chk("c_c0_wdata", mem_wdata, 32'h12345678);
    tick; settle;
    chk("c_c1_mem_wr", mem_wr, 1);
    chk("c_c1_addr", mem_addr, 32'h100);
    chk("c_c1_wdata", mem_wdata, 32'h12345678);
    tick; mem_ready = 1; settle;
    chk("c_dm_done", dm_done, 1);
    chk("c_done_addr", mem_addr, 32'h100);
    $display("txn C store addr=0x%0h wdata=0x%0h", mem_addr, mem_wdata);
    tick; dm_req = 0; mem_ready = 0; settle;
    chk("c_end_mem_req", mem_req, 0);
    chk("c_end_mem_wr", mem_wr, 0);

    // D: fetch only, ready after 3 wait cycles
    tick; if_req = 1; if_addr = 32'h44; settle;
    chk_ctrl("d_idle", 0, CTRL_FLUSH, CTRL_GO, CTRL_GO, CTRL_GO);
    for (int c = 0; c < 3; c++) begin
      tick; settle;
      chk("d_wait_mem_req", mem_req, 1);
      chk_ctrl("d_wait", 0, CTRL_FLUSH, CTRL_GO, CTRL_GO, CTRL_GO);
    end
    tick; mem_ready = 1; mem_rdata = 32'h0BADF00D; settle;
    chk("d_if_done", if_done, 1);
    chk("d_if_rdata", if_rdata, 32'h0BADF00D);
    chk_ctrl("d_done", 1, CTRL_GO, CTRL_GO, CTRL_GO, CTRL_GO);
    $display("txn D fetch addr=0x44 rdata=0x%0h", if_rdata);
    tick; if_req = 0; mem_ready = 0; settle;

    // E: async reset in the middle of a fetch
    tick; if_req = 1; if_addr = 32'h90; settle;
    tick; settle;
    chk("e_acc_mem_req", mem_req, 1);
    #1 rst_n = 1'b0; mem_ready = 1; mem_rdata = 32'h1;
    #1;
    chk("e_rst_mem_req", mem_req, 0);
    chk("e_rst_if_done", if_done, 0);
    tick;
    chk("e_rst_edge_mem_req", mem_req, 0);
    chk("e_rst_edge_if_done", if_done, 0);
    if_req = 0; mem_ready = 0; settle;
    chk_ctrl("e_rst_idle", 1, CTRL_GO, CTRL_GO, CTRL_GO, CTRL_GO);
    if_req = 1; rst_n = 1'b1; settle;
    chk("e_rel_no_grant", mem_req, 0);
    tick; settle;
    chk("e_regrant_mem_req", mem_req, 1);
    chk("e_regrant_addr", mem_addr, 32'h90);
    mem_ready = 1; mem_rdata = 32'hABCD; settle;
    chk("e_if_done", if_done, 1);
    $display("txn E fetch after reset rdata=0x%0h", if_rdata);
    tick; if_req = 0; mem_ready = 0; settle;

    // F: data access times out after 4 wait cycles, fetch pending
    tick; dm_req = 1; dm_wr = 0; dm_addr = 32'h500; if_req = 1; if_addr = 32'h600;
    mem_rdata = 32'h55; settle;
    for (int c = 0; c < 4; c++) begin
      tick; settle;
      chk("f_wait_dm_done", dm_done, 0);
      chk("f_wait_mem_req", mem_req, 1);
    end
    tick; settle;
    chk("f_to_dm_done", dm_done, 1);
    chk("f_to_dm_rdata", dm_rdata, 0);
    chk("f_to_if_done", if_done, 0);
    chk("f_to_err_pre", timeout_err, 0);
    $display("txn F load addr=0x500 timed out");
    tick; dm_req = 0; settle;
    chk("f_idle_mem_req", mem_req, 0);
    chk("f_err_set", timeout_err, 1);
    tick; mem_ready = 1; mem_rdata = 32'h77; settle;
    chk("f_if_done", if_done, 1);
    chk("f_if_rdata", if_rdata, 32'h77);
    chk("f_if_addr", mem_addr, 32'h600);
    chk("f_err_sticky", timeout_err, 1);
    $display("txn F fetch addr=0x600 rdata=0x%0h", if_rdata);
    tick; if_req = 0; mem_ready = 0; settle;
    tick; settle;
    chk("f_err_still", timeout_err, 1);
    rst_n = 1'b0; settle;
    chk("f_err_cleared", timeout_err, 0);
    rst_n = 1'b1;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
